// File: rtl/risc_pkg.sv
// Shared RISC-V front-end types and constants.
package risc_pkg;

  typedef enum logic [1:0] {
    PF_IDLE,
    PF_FETCH,
    PF_DRAIN
  } pf_state_e;

  localparam logic [31:0] RISCV_NOP = 32'h0000_0013;

endpackage

// File: rtl/fifo_sync.sv
// Small in-order synchronous queue with flush; read data comes straight from storage.
module fifo_sync #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   res,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             pop_ok;

  // Popping an empty queue is a no-op.
  assign pop_ok = pop & (count != '0);
  assign rdata  = mem[rptr];

  always_ff @(posedge clk) begin
    if (res) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      mem   <= '{default: '0};
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + AW'(1);
      end
      if (pop_ok) begin
        rptr <= rptr + AW'(1);
      end
      if (push & ~pop_ok) begin
        count <= count + CW'(1);
      end else if (pop_ok & ~push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/prefetch_buffer.sv
// Instruction prefetch queue: issues sequential fetches ahead of the core and
// flushes/restarts on redirect, discarding responses to stale requests.
module prefetch_buffer
  import risc_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     DEPTH    = 4
) (
  input  logic            clk,
  input  logic            res,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr_data,
  output logic [XLEN-1:0] instr_pc
);

  localparam int unsigned     CW         = $clog2(DEPTH) + 1;
  localparam int unsigned     SW         = CW + 1;
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  pf_state_e         state;
  logic [XLEN-1:0]   fetch_pc;
  logic [XLEN-1:0]   resp_pc;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     discard;
  logic [CW-1:0]     count;
  logic [CW-1:0]     rsp_dec;
  logic [CW-1:0]     out_after_rsp;
  logic [SW-1:0]     credit_used;
  logic [2*XLEN-1:0] head;
  logic [XLEN-1:0]   target_pc;
  logic              grant;
  logic              push;
  logic              pop;

  // Queue entries plus in-flight requests never exceed DEPTH, so pushes cannot overflow.
  assign credit_used   = {1'b0, count} + {1'b0, outstanding};
  assign imem_req      = (state == PF_FETCH) & ~redirect_valid & (credit_used < SW'(DEPTH));
  assign grant         = imem_req & imem_gnt;
  assign rsp_dec       = CW'(imem_rvalid);
  assign out_after_rsp = outstanding - rsp_dec;
  assign target_pc     = redirect_pc & ALIGN_MASK;

  assign push        = imem_rvalid & ~redirect_valid & (discard == '0);
  assign pop         = instr_valid & instr_ready & ~redirect_valid;
  assign instr_valid = (count != '0);
  assign imem_addr   = fetch_pc;
  assign {instr_pc, instr_data} = head;

  fifo_sync #(
    .WIDTH (2 * XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .res   (res),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata ({resp_pc, imem_rdata}),
    .rdata (head),
    .count (count)
  );

  // State, PCs and credit counters; redirect overrides everything else in its cycle.
  always_ff @(posedge clk) begin
    if (res) begin
      state       <= PF_IDLE;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else if (redirect_valid) begin
      fetch_pc    <= target_pc;
      resp_pc     <= target_pc;
      outstanding <= out_after_rsp;
      discard     <= out_after_rsp;
      state       <= (out_after_rsp != '0) ? PF_DRAIN : PF_FETCH;
    end else begin
      outstanding <= out_after_rsp + CW'(grant);
      if (grant) begin
        fetch_pc <= fetch_pc + PC_STEP;
      end
      if (imem_rvalid) begin
        if (discard != '0) begin
          discard <= discard - CW'(1);
        end else begin
          resp_pc <= resp_pc + PC_STEP;
        end
      end
      case (state)
        PF_IDLE:  state <= PF_FETCH;
        PF_FETCH: state <= PF_FETCH;
        PF_DRAIN: if (discard <= rsp_dec) state <= PF_FETCH;
        default:  state <= PF_IDLE;
      endcase
    end
  end

endmodule
